// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the memory-mapped UART receiver:
//   - address window (UART_RX_BASE / UART_RX_SIZE) and is_uart_rx_mem() decode
//   - register offsets (RX_DATA, STATUS, CTRL) and STATUS/CTRL bit indices
//   - receive FSM state type
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state, 8E1 frames).
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam logic [31:0] UART_RX_BASE = 32'h0000_0300;
    localparam logic [31:0] UART_RX_SIZE = 32'h0000_0010;

    function automatic logic is_uart_rx_mem(input logic [31:0] a);
        return (a >= UART_RX_BASE) && (a < (UART_RX_BASE + UART_RX_SIZE));
    endfunction

    localparam logic [7:0] REG_RX_DATA = 8'h00;
    localparam logic [7:0] REG_STATUS  = 8'h04;
    localparam logic [7:0] REG_CTRL    = 8'h08;

    localparam int unsigned STAT_NOT_EMPTY  = 0;
    localparam int unsigned STAT_FULL       = 1;
    localparam int unsigned STAT_OVERRUN    = 2;
    localparam int unsigned STAT_FRAME_ERR  = 3;
    localparam int unsigned STAT_PARITY_ERR = 4;
    localparam int unsigned STAT_COUNT_LSB  = 8;

    localparam int unsigned CTRL_IRQ_EN = 0;
    localparam int unsigned CTRL_FLUSH  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// ---------------------------------------------------------------------------
// rx_fifo
// Synchronous FIFO holding received bytes. Pointers carry one extra wrap bit
// so full/empty/count fall out of a plain pointer difference.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_data  write request and data (ignored when full unless popping)
//   pop              read request (ignored when empty)
//   flush            empties the FIFO; a same-cycle push/pop is discarded
//   pop_data         head entry (combinational)
//   full, empty      status
//   count            number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign count    = wptr - rptr;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign pop_data = mem[rptr[AW-1:0]];

    // When full, a simultaneous pop frees the slot being written this cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW + 1)'(1);
            if (do_pop)  rptr <= rptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Memory-mapped UART receiver. Deserialises 8N1 frames (8E1 when
// UART_RX_PARITY_EN is defined) from rx into an RX FIFO drained by the CPU.
// Registers (offset from UART_RX_BASE, low address byte decoded):
//   0x00 RX_DATA (RO)  [7:0] FIFO head, 0 when empty; first read cycle pops
//   0x04 STATUS        [0] not_empty [1] full [2] overrun W1C [3] frame_err W1C
//                      [4] parity_err W1C [15:8] fill count
//   0x08 CTRL          [0] irq_en RW, [1] flush (self-clearing, reads 0)
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   addr, write_data            bus address / write data
//   write_enable, read_enable   strobes, already qualified by address decode
//   read_data, uart_rx_valid    combinational read data and its valid flag
//   rx                          asynchronous serial input, idle high
//   rx_interrupt                registered level interrupt
// Optional feature macro: UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        uart_rx_valid,
    input  logic        rx,
    output logic        rx_interrupt
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;

    // ---------------- synchroniser and edge detect ----------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // ---------------- receive FSM ----------------
    rx_state_e     state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          rx_push;
    logic          frame_set;
`ifdef UART_RX_PARITY_EN
    logic          parity_bad, parity_bad_n;
    logic          parity_set;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
`ifdef UART_RX_PARITY_EN
            parity_bad <= parity_bad_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + CW'(1);
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_n = parity_bad;
        parity_set   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                baud_cnt_n = '0;
                bit_idx_n  = '0;
`ifdef UART_RX_PARITY_EN
                parity_bad_n = 1'b0;
`endif
                if (rx_fall) state_n = ST_START;
            end
            ST_START: begin
                // Mid-start-bit check: a line back high here was only a glitch.
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_n = '0;
                    shift_n    = {rx_sync, shift[7:1]};
                    bit_idx_n  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_n   = '0;
                    parity_bad_n = rx_sync ^ (^shift);
                    state_n      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = ST_IDLE;
                    if (!rx_sync) begin
                        frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad) begin
                        parity_set = 1'b1;
`endif
                    end else begin
                        rx_push = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    logic [7:0]       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             pop;
    logic             flush;

    rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (shift),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- register file ----------------
    logic [7:0] offs;
    logic       data_rd;
    logic       rd_prev;
    logic       status_wr;
    logic       ctrl_wr;
    logic       irq_en;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_set;
    logic       unused_bits;

    assign offs        = addr[7:0];
    assign data_rd     = read_enable && (offs == REG_RX_DATA);
    assign status_wr   = write_enable && (offs == REG_STATUS);
    assign ctrl_wr     = write_enable && (offs == REG_CTRL);
    assign flush       = ctrl_wr && write_data[CTRL_FLUSH];
    // Only the first cycle of a (possibly stalled) RX_DATA strobe pops.
    assign pop         = data_rd && !rd_prev && !fifo_empty;
    assign overrun_set = rx_push && fifo_full && !pop && !flush;
    assign unused_bits = ^{addr[31:8], write_data[31:4]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_prev      <= 1'b0;
            irq_en       <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
            rx_interrupt <= 1'b0;
        end else begin
            rd_prev   <= data_rd;
            overrun   <= overrun_set | (overrun & ~(status_wr & write_data[STAT_OVERRUN]));
            frame_err <= frame_set | (frame_err & ~(status_wr & write_data[STAT_FRAME_ERR]));
            if (ctrl_wr) irq_en <= write_data[CTRL_IRQ_EN];
            rx_interrupt <= irq_en & (!fifo_empty | overrun | frame_err | parity_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_set | (parity_err & ~(status_wr & write_data[STAT_PARITY_ERR]));
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        if (read_enable) begin
            case (offs)
                REG_RX_DATA: begin
                    if (!fifo_empty) read_data[7:0] = head;
                end
                REG_STATUS: begin
                    read_data[STAT_NOT_EMPTY]               = !fifo_empty;
                    read_data[STAT_FULL]                    = fifo_full;
                    read_data[STAT_OVERRUN]                 = overrun;
                    read_data[STAT_FRAME_ERR]               = frame_err;
                    read_data[STAT_PARITY_ERR]              = parity_err;
                    read_data[STAT_COUNT_LSB +: 8]          = 8'(fifo_count);
                end
                REG_CTRL: begin
                    read_data[CTRL_IRQ_EN] = irq_en;
                end
                default: read_data = '0;
            endcase
        end
    end

    assign uart_rx_valid = read_enable;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx at 16 clocks/bit, FIFO depth 4.
// Expected bytes are queued when a good frame is sent and popped when the
// bench reads RX_DATA.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        uart_rx_valid;
    logic        rx = 1'b1;
    logic        rx_interrupt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    int          irq_rise;
    logic [31:0] rd;
`ifdef UART_RX_PARITY_EN
    logic        par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .read_data     (read_data),
        .uart_rx_valid (uart_rx_valid),
        .rx            (rx),
        .rx_interrupt  (rx_interrupt)
    );

    initial begin
        #500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [7:0] offs, output logic [31:0] d);
        addr        = UART_RX_BASE + {24'h0, offs};
        read_enable = 1'b1;
        #1;
        d = read_data;
        check("rd_valid", {31'h0, uart_rx_valid}, 32'h1);
        @(negedge clk);
        read_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] offs, input logic [31:0] d);
        addr         = UART_RX_BASE + {24'h0, offs};
        write_data   = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        write_data   = '0;
        @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [7:0] offs, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(offs, d);
        check(tag, d, exp);
    endtask

    task automatic read_sb(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        bus_read(REG_RX_DATA, d);
        check(tag, d, {24'h0, e});
    endtask

    task automatic expect_byte(input logic [7:0] b);
        if (sb.size() < DEPTH) sb.push_back(b);
    endtask

    // Drives one frame; records the first stop-bit clock at which rx_interrupt is seen high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        irq_rise = -1;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`endif
        rx = stop_bit;
        for (int k = 1; k <= int'(CPB); k++) begin
            tick(1);
            if (irq_rise < 0 && rx_interrupt === 1'b1) irq_rise = k;
        end
        rx = 1'b1;
    endtask

    initial begin
        // reset state
        tick(3);
        check("reset_irq", {31'h0, rx_interrupt}, 32'h0);
        check("reset_rdata", read_data, 32'h0);
        check("reset_valid", {31'h0, uart_rx_valid}, 32'h0);
        rst = 1'b1;
        tick(2);
        check_reg("reset_status", REG_STATUS, 32'h0);
        check_reg("reset_ctrl", REG_CTRL, 32'h0);

        // 1: single byte
        send_frame(8'hA5, 1'b1);
        expect_byte(8'hA5);
        check_reg("t1_status", REG_STATUS, 32'h0000_0101);
        read_sb("t1_data");
        check_reg("t1_status_empty", REG_STATUS, 32'h0);

        // 2: interrupt
        bus_write(REG_CTRL, 32'h1);
        check_reg("t2_ctrl", REG_CTRL, 32'h1);
        send_frame(8'h3C, 1'b1);
        expect_byte(8'h3C);
        check("t2_irq_window", {31'h0, (irq_rise >= 9 && irq_rise <= 14)}, 32'h1);
        check("t2_irq_high", {31'h0, rx_interrupt}, 32'h1);
        read_sb("t2_data");
        tick(1);
        check("t2_irq_low", {31'h0, rx_interrupt}, 32'h0);
        bus_write(REG_CTRL, 32'h0);

        // 3: overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            expect_byte(8'(i));
        end
        check_reg("t3_status_full", REG_STATUS, 32'h0000_0407);
        for (int i = 0; i < 4; i++) read_sb("t3_data");
        check_reg("t3_status_drained", REG_STATUS, 32'h0000_0004);
        bus_write(REG_STATUS, 32'h4);
        check_reg("t3_overrun_clr", REG_STATUS, 32'h0);

        // 4: frame error and glitch rejection
        send_frame(8'h55, 1'b0);
        tick(CPB);
        check_reg("t4_frame_err", REG_STATUS, 32'h0000_0008);
        read_sb("t4_empty_read");
        bus_write(REG_STATUS, 32'h8);
        check_reg("t4_frame_clr", REG_STATUS, 32'h0);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * CPB);
        check_reg("t4_glitch", REG_STATUS, 32'h0);

        // 5: held read pops once
        send_frame(8'h11, 1'b1);
        expect_byte(8'h11);
        send_frame(8'h22, 1'b1);
        expect_byte(8'h22);
        check_reg("t5_count2", REG_STATUS, 32'h0000_0201);
        addr        = UART_RX_BASE + {24'h0, REG_RX_DATA};
        read_enable = 1'b1;
        #1;
        check("t5_held_first", read_data, {24'h0, sb.pop_front()});
        tick(2);
        read_enable = 1'b0;
        tick(1);
        check_reg("t5_count1", REG_STATUS, 32'h0000_0101);
        read_sb("t5_second");

        // flush
        send_frame(8'h77, 1'b1);
        expect_byte(8'h77);
        bus_write(REG_CTRL, 32'h2);
        sb.delete();
        check_reg("flush_status", REG_STATUS, 32'h0);
        check_reg("flush_ctrl", REG_CTRL, 32'h0);

        // 5b: reset mid-frame
        bus_write(REG_CTRL, 32'h1);
        send_frame(8'h99, 1'b1);
        expect_byte(8'h99);
        tick(2);
        check("t5_irq_before_rst", {31'h0, rx_interrupt}, 32'h1);
        rx = 1'b0;
        tick(3 * CPB);
        rst = 1'b0;
        #1;
        check("t5_rst_irq", {31'h0, rx_interrupt}, 32'h0);
        check("t5_rst_rdata", read_data, 32'h0);
        check("t5_rst_valid", {31'h0, uart_rx_valid}, 32'h0);
        sb.delete();
        rx = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        check_reg("t5_post_rst_status", REG_STATUS, 32'h0);
        check_reg("t5_post_rst_ctrl", REG_CTRL, 32'h0);
        send_frame(8'h5A, 1'b1);
        expect_byte(8'h5A);
        read_sb("t5_post_rst_data");

`ifdef UART_RX_PARITY_EN
        // 6: parity
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        check_reg("t6_parity_err", REG_STATUS, 32'h0000_0010);
        read_sb("t6_dropped");
        bus_write(REG_STATUS, 32'h10);
        send_frame(8'h07, 1'b1);
        expect_byte(8'h07);
        check_reg("t6_status_ok", REG_STATUS, 32'h0000_0101);
        read_sb("t6_data");
`endif

        check("sb_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
